sample_sum_fsm: RTL and testbench

SAMPLE_SUM_FSM -- requirements
Module: sample_sum_fsm

---
 rtl/sample_sum_fsm.sv | 199 +++++++++++++++++++
 tb/tb_sample_sum_fsm.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sample_sum_fsm.sv
// sample_sum_fsm: watches a sample bus for changes and sums DEPTH changed
// values into one window result. The result is held until a valid/ready
// handshake takes it. Changes that arrive while a result is pending are
// dropped and flagged through the sticky overrun bit.
//
// Handshake: w_valid rises on the edge that captures the DEPTH-th change.
// w, w_valid and w_sat then stay frozen until an edge where w_valid and
// w_ready are both high. That edge consumes the result. w_ready has no
// effect while w_valid is low.
module sample_sum_fsm #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int SAT   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         sample,
  output logic [WIDTH-1:0]         w,
  output logic                     w_valid,
  input  logic                     w_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     w_sat,
  output logic                     overrun,
  output logic [1:0]               state_dbg
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = WIDTH + $clog2(DEPTH);

  // State encoding. IDLE means an empty window. ACCUM means a window that
  // is partly filled. HOLD means a result is waiting for the consumer.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Largest value w can carry, zero-extended to the accumulator width.
  localparam logic [AW-1:0] W_MAX = {{(AW-WIDTH){1'b0}}, {WIDTH{1'b1}}};

  // The last count value before a window completes.
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

  logic [1:0]       state_q,   state_d;
  logic [WIDTH-1:0] prev_q,    prev_d;
  logic [AW-1:0]    acc_q,     acc_d;
  logic [CW-1:0]    count_q,   count_d;
  logic [WIDTH-1:0] w_q,       w_d;
  logic             w_valid_q, w_valid_d;
  logic             w_sat_q,   w_sat_d;
  logic             overrun_q, overrun_d;

  logic             change;
  logic             handshake;
  logic [AW-1:0]    sample_ext;
  logic [AW-1:0]    acc_sum;
  logic             sum_over;
  logic [WIDTH-1:0] w_result;
  logic             w_result_sat;

  // Detect a change, detect a handshake, and form the running sum with the
  // current sample. The accumulator is wide enough to hold DEPTH samples at
  // their maximum value, so this addition cannot overflow.
  always_comb begin
    change     = en && (sample != prev_q);
    handshake  = w_valid_q && w_ready;
    sample_ext = {{(AW-WIDTH){1'b0}}, sample};
    acc_sum    = acc_q + sample_ext;
    sum_over   = (acc_sum > W_MAX);
  end

  // Reduce the full-width sum to the output width. SAT selects clamping or
  // plain truncation. w_sat can only be set when clamping is selected.
  always_comb begin
    w_result     = acc_sum[WIDTH-1:0];
    w_result_sat = 1'b0;
    if (SAT != 0) begin
      if (sum_over) begin
        w_result     = {WIDTH{1'b1}};
        w_result_sat = 1'b1;
      end
    end
  end

  // Next-state logic for the window FSM. clr has priority over a change and
  // over a handshake. w is never cleared here, so it keeps the last result.
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    acc_d     = acc_q;
    count_d   = count_q;
    w_d       = w_q;
    w_valid_d = w_valid_q;
    w_sat_d   = w_sat_q;
    overrun_d = overrun_q;

    // prev_q follows sample whenever detection is enabled. This includes
    // the HOLD case where the change itself is dropped.
    if (en) begin
      prev_d = sample;
    end

    if (clr) begin
      state_d   = ST_IDLE;
      prev_d    = sample;
      acc_d     = '0;
      count_d   = '0;
      w_valid_d = 1'b0;
      w_sat_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (change) begin
            state_d = ST_ACCUM;
            acc_d   = sample_ext;
            count_d = CW'(1);
          end
        end

        ST_ACCUM: begin
          if (change) begin
            if (count_q == LAST_CNT) begin
              // This change completes the window. Publish the result and
              // start the next window empty.
              state_d   = ST_HOLD;
              w_d       = w_result;
              w_sat_d   = w_result_sat;
              w_valid_d = 1'b1;
              acc_d     = '0;
              count_d   = '0;
            end else begin
              acc_d   = acc_sum;
              count_d = count_q + CW'(1);
            end
          end
        end

        ST_HOLD: begin
          if (handshake) begin
            w_valid_d = 1'b0;
            if (change) begin
              // A change on the consuming edge is the first sample of the
              // next window. The accumulator is already zero at this point.
              state_d = ST_ACCUM;
              acc_d   = sample_ext;
              count_d = CW'(1);
            end else begin
              state_d = ST_IDLE;
            end
          end else if (change) begin
            overrun_d = 1'b1;
          end
        end

        default: begin
          state_d   = ST_IDLE;
          acc_d     = '0;
          count_d   = '0;
          w_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State registers. Reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      prev_q    <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      w_q       <= '0;
      w_valid_q <= 1'b0;
      w_sat_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      w_q       <= w_d;
      w_valid_q <= w_valid_d;
      w_sat_q   <= w_sat_d;
      overrun_q <= overrun_d;
    end
  end

  // Output wiring. Every output comes directly from a register.
  always_comb begin
    w         = w_q;
    w_valid   = w_valid_q;
    count     = count_q;
    w_sat     = w_sat_q;
    overrun   = overrun_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_sample_sum_fsm.sv
// Bench for sample_sum_fsm. Two instances share the same stimulus. One
// instance saturates its result and the other wraps it. A window-level
// reference model predicts every output. Directed scenarios pin known
// values, and a randomized phase follows them.
module tb_sample_sum_fsm;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         clr;
  logic         w_ready;
  logic [W-1:0] sample;

  always #5 clk = ~clk;

  logic [W-1:0]  s_w,  x_w;
  logic          s_w_valid, x_w_valid;
  logic [CW-1:0] s_count, x_count;
  logic          s_w_sat, x_w_sat;
  logic          s_overrun, x_overrun;
  logic [1:0]    s_state, x_state;

  sample_sum_fsm #(.WIDTH(W), .DEPTH(D), .SAT(1)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .sample(sample),
    .w(s_w), .w_valid(s_w_valid), .w_ready(w_ready), .count(s_count),
    .w_sat(s_w_sat), .overrun(s_overrun), .state_dbg(s_state)
  );

  sample_sum_fsm #(.WIDTH(W), .DEPTH(D), .SAT(0)) dut_wrap (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .sample(sample),
    .w(x_w), .w_valid(x_w_valid), .w_ready(w_ready), .count(x_count),
    .w_sat(x_w_sat), .overrun(x_overrun), .state_dbg(x_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The window is a list of the captured samples. The result is computed
  // from their plain integer sum once the list reaches D entries.
  int m_prev  = 0;
  int m_win[$];
  bit m_valid = 0;
  int m_w_s   = 0;
  int m_w_x   = 0;
  bit m_sat_s = 0;
  bit m_ov    = 0;

  task automatic model_step();
    bit chg;
    int sum;
    if (!reset) begin
      m_prev = 0; m_win.delete(); m_valid = 0;
      m_w_s = 0; m_w_x = 0; m_sat_s = 0; m_ov = 0;
    end else if (clr) begin
      m_prev = int'(sample); m_win.delete(); m_valid = 0;
      m_sat_s = 0; m_ov = 0;
    end else begin
      chg = en && (int'(sample) != m_prev);
      if (en) m_prev = int'(sample);
      if (m_valid) begin
        if (w_ready) begin
          m_valid = 0;
          if (chg) m_win.push_back(int'(sample));
        end else if (chg) begin
          m_ov = 1;
        end
      end else if (chg) begin
        m_win.push_back(int'(sample));
        if (m_win.size() == D) begin
          sum = 0;
          foreach (m_win[i]) sum += m_win[i];
          m_w_s   = (sum > 15) ? 15 : sum;
          m_sat_s = (sum > 15);
          m_w_x   = sum % 16;
          m_valid = 1;
          m_win.delete();
        end
      end
    end
  endtask

  always @(posedge clk or negedge reset) model_step();

  // Compare every output of both instances on every falling edge.
  always @(negedge clk) begin
    chk("s_w",       s_w,       m_w_s);
    chk("s_w_valid", s_w_valid, m_valid);
    chk("s_count",   s_count,   m_win.size());
    chk("s_w_sat",   s_w_sat,   m_sat_s);
    chk("s_overrun", s_overrun, m_ov);
    chk("x_w",       x_w,       m_w_x);
    chk("x_w_valid", x_w_valid, m_valid);
    chk("x_count",   x_count,   m_win.size());
    chk("x_w_sat",   x_w_sat,   0);
    chk("x_overrun", x_overrun, m_ov);
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge, well away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] s, input logic r);
    sample  = s;
    w_ready = r;
    tick();
  endtask

  // Assert reset between clock edges and hold it across one rising edge.
  task automatic reset_pulse();
    #2 reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; en = 1'b0; clr = 1'b0; w_ready = 1'b0; sample = '0;
    #1 reset = 1'b0;
    repeat (3) tick();
    chk("rst_w",       s_w,       0);
    chk("rst_w_valid", s_w_valid, 0);
    chk("rst_count",   s_count,   0);
    chk("rst_overrun", s_overrun, 0);

    // Four consecutive changes produce 1+2+3+4 = 10.
    reset = 1'b1; en = 1'b1;
    drive(4'd1, 1'b0); drive(4'd2, 1'b0); drive(4'd3, 1'b0);
    chk("seq_count3", s_count, 3);
    drive(4'd4, 1'b0);
    chk("seq_w",       s_w,       4'hA);
    chk("seq_w_valid", s_w_valid, 1);
    chk("seq_count",   s_count,   0);
    chk("seq_w_sat",   s_w_sat,   0);

    // Handshake plus a change starts the next window. 8+9+10+11 = 38.
    drive(4'd8, 1'b1);
    chk("hs_valid0", s_w_valid, 0);
    chk("hs_count1", s_count,   1);
    drive(4'd9, 1'b0); drive(4'd10, 1'b0); drive(4'd11, 1'b0);
    chk("sat_w",    s_w,     4'hF);
    chk("sat_flag", s_w_sat, 1);
    chk("wrap_w",   x_w,     4'h6);
    chk("wrap_flag", x_w_sat, 0);

    // A handshake without a change returns to idle and w is kept.
    drive(4'd11, 1'b1);
    chk("hs_idle_valid", s_w_valid, 0);
    chk("hs_idle_w",     s_w,       4'hF);
    chk("hs_idle_state", s_state,   0);

    // A constant sample and a disabled en leave the count unchanged.
    drive(4'd3, 1'b0);
    repeat (5) tick();
    chk("const_count", s_count, 1);
    drive(4'd5, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 4; i++) drive(4'(i * 3 + 1), 1'b0);
    chk("en0_count", s_count,   2);
    chk("en0_valid", s_w_valid, 0);
    en = 1'b1;
    drive(4'd5, 1'b0);
    chk("en1_same", s_count, 2);

    // Fill the window (3+5+1+2 = 11), then lose one change while in HOLD.
    drive(4'd1, 1'b0); drive(4'd2, 1'b0);
    chk("hold_w", s_w, 4'hB);
    drive(4'd9, 1'b0);
    chk("ovr_flag", s_overrun, 1);
    chk("ovr_w",    s_w,       4'hB);
    drive(4'd7, 1'b1);
    chk("ovr_hs_valid", s_w_valid, 0);
    chk("ovr_hs_count", s_count,   1);
    drive(4'd1, 1'b0); drive(4'd2, 1'b0); drive(4'd3, 1'b0);
    chk("next_w", s_w, 4'hD);

    // clr wins over a change and a handshake on the same edge.
    clr = 1'b1;
    drive(4'd4, 1'b1);
    clr = 1'b0;
    chk("clr_state",   s_state,   0);
    chk("clr_count",   s_count,   0);
    chk("clr_overrun", s_overrun, 0);
    chk("clr_valid",   s_w_valid, 0);
    chk("clr_w",       s_w,       4'hD);
    drive(4'd4, 1'b0);
    chk("clr_prev", s_count, 0);

    // Reset asserted mid-window takes effect without waiting for an edge.
    drive(4'd5, 1'b0); drive(4'd6, 1'b0);
    chk("pre_rst_count", s_count, 2);
    #2 reset = 1'b0;
    #1;
    chk("arst_w",       s_w,       0);
    chk("arst_count",   s_count,   0);
    chk("arst_valid",   s_w_valid, 0);
    chk("arst_overrun", s_overrun, 0);
    chk("arst_x_w",     x_w,       0);
    tick();
    reset = 1'b1;
    drive(4'd5, 1'b0); drive(4'd6, 1'b0); drive(4'd7, 1'b0); drive(4'd8, 1'b0);
    chk("post_rst_sat",  s_w,     4'hF);
    chk("post_rst_flag", s_w_sat, 1);
    chk("post_rst_wrap", x_w,     4'hA);

    // Randomized phase, checked by the model on every falling edge.
    for (int i = 0; i < 2500; i++) begin
      en      = ($urandom_range(0, 9) != 0);
      clr     = ($urandom_range(0, 49) == 0);
      w_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) != 0) sample = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) reset_pulse();
      else tick();
    end
    clr = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
